// File: rtl/mul_seq_ctrl_if.sv
// Handshake, operand/result and external-adder signals of the MUL sequencer.
// The control unit is the master; the sequencer is the slave.
interface mul_seq_ctrl_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result_hi;
   logic [WIDTH-1:0] result_lo;
   logic             result_zero;
   logic [WIDTH-1:0] add_a;
   logic [WIDTH-1:0] add_b;
   logic [WIDTH-1:0] add_c;

   modport master (
      output start, op_a, op_b,
      input  busy, done, result_hi, result_lo, result_zero
   );

   modport slave (
      input  start, op_a, op_b, add_c,
      output busy, done, result_hi, result_lo, result_zero, add_a, add_b
   );

   modport adder (
      input  add_a, add_b,
      output add_c
   );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Unsigned shift-and-add multiply sequencer borrowing the core's WIDTH-bit adder:
// one add per RUN cycle, WIDTH cycles per product, result registered on entry to DONE.
module mul_seq_ctrl #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   mul_seq_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_acc_hi;
   logic [WIDTH-1:0] r_acc_lo;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_res_hi;
   logic [WIDTH-1:0] r_res_lo;
   logic             r_res_zero;

   logic             w_load;
   logic             w_step;
   logic             w_last;
   logic             w_carry;
   logic [WIDTH-1:0] w_add_a;
   logic [WIDTH-1:0] w_add_b;
   logic [WIDTH-1:0] w_hi_nxt;
   logic [WIDTH-1:0] w_lo_nxt;

   // The adder has no carry-out port; an unsigned wrap shows up as sum < operand A.
   assign w_add_a  = r_acc_hi;
   assign w_add_b  = r_acc_lo[0] ? r_mcand : {WIDTH{1'b0}};
   assign w_carry  = (bus.add_c < w_add_a);
   assign w_hi_nxt = {w_carry, bus.add_c[WIDTH-1:1]};
   assign w_lo_nxt = {bus.add_c[0], r_acc_lo[WIDTH-1:1]};
   assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

   assign bus.add_a       = w_add_a;
   assign bus.add_b       = w_add_b;
   assign bus.busy        = (r_state == S_RUN);
   assign bus.done        = (r_state == S_DONE);
   assign bus.result_hi   = r_res_hi;
   assign bus.result_lo   = r_res_lo;
   assign bus.result_zero = r_res_zero;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode; start is only honoured from IDLE or DONE.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_step      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_load      = 1'b1;
               w_state_nxt = S_RUN;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_RUN: begin
            w_step = 1'b1;
            if (w_last) begin
               w_state_nxt = S_DONE;
            end else begin
               w_state_nxt = S_RUN;
            end
         end
         S_DONE: begin
            if (bus.start) begin
               w_load      = 1'b1;
               w_state_nxt = S_RUN;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Operand capture and one shift-add iteration per RUN cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mcand  <= {WIDTH{1'b0}};
         r_acc_hi <= {WIDTH{1'b0}};
         r_acc_lo <= {WIDTH{1'b0}};
         r_cnt    <= {CNT_W{1'b0}};
      end else if (w_load) begin
         r_mcand  <= bus.op_a;
         r_acc_hi <= {WIDTH{1'b0}};
         r_acc_lo <= bus.op_b;
         r_cnt    <= {CNT_W{1'b0}};
      end else if (w_step) begin
         r_acc_hi <= w_hi_nxt;
         r_acc_lo <= w_lo_nxt;
         r_cnt    <= r_cnt + CNT_W'(1);
      end else begin
         r_acc_hi <= r_acc_hi;
         r_acc_lo <= r_acc_lo;
         r_cnt    <= r_cnt;
      end
   end

   // Result registers only see the final iteration, so intermediate sums never leak out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_res_hi   <= {WIDTH{1'b0}};
         r_res_lo   <= {WIDTH{1'b0}};
         r_res_zero <= 1'b0;
      end else if (w_step && w_last) begin
         r_res_hi   <= w_hi_nxt;
         r_res_lo   <= w_lo_nxt;
         r_res_zero <= (w_hi_nxt == {WIDTH{1'b0}}) && (w_lo_nxt == {WIDTH{1'b0}});
      end else begin
         r_res_hi   <= r_res_hi;
         r_res_lo   <= r_res_lo;
         r_res_zero <= r_res_zero;
      end
   end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: fixed vector table, random products checked
// against plain 64-bit multiplication, and hand-written handshake/reset sequences.
module tb_mul_seq_ctrl;
   localparam int W = 32;

   typedef struct {
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic [2*W-1:0] exp;
      logic           exp_zero;
      bit             want_carry;
   } vec_t;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_fail;
   int   carry_cnt;

   mul_seq_ctrl_if #(.WIDTH(W)) bus_if ();

   mul_seq_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   // Stand-in for the core's combinational adder.
   assign bus_if.add_c = bus_if.add_a + bus_if.add_b;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every cycle in which the adder wrapped during a run.
   always @(negedge clk) begin
      if (bus_if.busy && (bus_if.add_c < bus_if.add_a)) carry_cnt <= carry_cnt + 1;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Called at a negedge: present a one-cycle start, then scramble the operands.
   task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
      bus_if.start = 1'b1;
      bus_if.op_a  = a;
      bus_if.op_b  = b;
      @(negedge clk);
      bus_if.start = 1'b0;
      bus_if.op_a  = $urandom;
      bus_if.op_b  = $urandom;
   endtask

   task automatic wait_done(output int busy_n, output bit seen);
      busy_n = 0;
      seen   = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (bus_if.done) begin
            seen = 1'b1;
            break;
         end
         if (bus_if.busy) busy_n++;
         @(negedge clk);
      end
   endtask

   task automatic run_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [2*W-1:0] exp, input logic exp_zero);
      int bn;
      bit seen;
      launch(a, b);
      wait_done(bn, seen);
      chk({tag, ".done_seen"}, 64'(seen), 64'd1);
      chk({tag, ".busy_cycles"}, 64'(bn), 64'd32);
      chk({tag, ".product"}, {bus_if.result_hi, bus_if.result_lo}, exp);
      chk({tag, ".zero"}, 64'(bus_if.result_zero), 64'(exp_zero));
      @(negedge clk);
      chk({tag, ".done_one_cycle"}, {62'd0, bus_if.done, bus_if.busy}, 64'd0);
      repeat (3) @(negedge clk);
      chk({tag, ".hold"}, {bus_if.result_hi, bus_if.result_lo}, exp);
      chk({tag, ".hold_zero"}, 64'(bus_if.result_zero), 64'(exp_zero));
   endtask

   initial begin
      vec_t           vecs[8];
      logic [W-1:0]   ra;
      logic [W-1:0]   rb;
      logic [2*W-1:0] model;
      int             bn;
      int             bn2;
      int             extra;
      int             c0;
      bit             seen;

      vecs[0] = '{32'd3,          32'd5,          64'h0000_0000_0000_000F, 1'b0, 1'b0};
      vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001, 1'b0, 1'b1};
      vecs[2] = '{32'h1234_5678,  32'd0,          64'h0000_0000_0000_0000, 1'b1, 1'b0};
      vecs[3] = '{32'd0,          32'hDEAD_BEEF,  64'h0000_0000_0000_0000, 1'b1, 1'b0};
      vecs[4] = '{32'd1,          32'd1,          64'h0000_0000_0000_0001, 1'b0, 1'b0};
      vecs[5] = '{32'd1,          32'hFFFF_FFFF,  64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0};
      vecs[6] = '{32'h8000_0000,  32'd2,          64'h0000_0001_0000_0000, 1'b0, 1'b0};
      vecs[7] = '{32'hFFFF_FFFF,  32'd2,          64'h0000_0001_FFFF_FFFE, 1'b0, 1'b0};

      n_cmp        = 0;
      n_fail       = 0;
      carry_cnt    = 0;
      rst_n        = 1'b0;
      bus_if.start = 1'b0;
      bus_if.op_a  = 32'd0;
      bus_if.op_b  = 32'd0;

      #3;
      chk("reset.busy_done", {62'd0, bus_if.busy, bus_if.done}, 64'd0);
      chk("reset.result", {bus_if.result_hi, bus_if.result_lo}, 64'd0);
      chk("reset.zero", 64'(bus_if.result_zero), 64'd0);
      chk("reset.add_a", 64'(bus_if.add_a), 64'd0);
      #9 rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         c0 = carry_cnt;
         run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].exp_zero);
         if (vecs[i].want_carry) chk($sformatf("vec%0d.carry_seen", i), 64'(carry_cnt > c0), 64'd1);
      end

      // Zero result must survive a longer idle stretch.
      run_check("zero_hold", 32'h1234_5678, 32'd0, 64'd0, 1'b1);
      repeat (7) @(negedge clk);
      chk("zero_hold.long", {bus_if.result_hi, bus_if.result_lo}, 64'd0);
      chk("zero_hold.long_zero", 64'(bus_if.result_zero), 64'd1);

      for (int i = 0; i < 30; i++) begin
         ra = $urandom;
         rb = $urandom;
         if (i % 5 == 1) ra = ra & 32'h0000_00FF;
         if (i % 7 == 2) rb = rb & 32'h0000_000F;
         model = 64'(ra) * 64'(rb);
         run_check($sformatf("rand%0d", i), ra, rb, model, model == 64'd0);
      end

      // Start pulse during RUN cycle 10 must be ignored.
      launch(32'd7, 32'd9);
      bn = 0;
      for (int k = 0; k < 10; k++) begin
         if (bus_if.busy) bn++;
         if (k == 9) begin
            bus_if.start = 1'b1;
            bus_if.op_a  = 32'd2;
            bus_if.op_b  = 32'd2;
         end
         @(negedge clk);
         bus_if.start = 1'b0;
      end
      wait_done(bn2, seen);
      chk("ignore.done_seen", 64'(seen), 64'd1);
      chk("ignore.busy_cycles", 64'(bn + bn2), 64'd32);
      chk("ignore.product", {bus_if.result_hi, bus_if.result_lo}, 64'd63);
      extra = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (bus_if.done || bus_if.busy) extra++;
      end
      chk("ignore.no_second_op", 64'(extra), 64'd0);

      // Back-to-back: start held through the DONE cycle.
      launch(32'd6, 32'd7);
      wait_done(bn, seen);
      chk("b2b.first_done", 64'(seen), 64'd1);
      chk("b2b.first_product", {bus_if.result_hi, bus_if.result_lo}, 64'd42);
      bus_if.start = 1'b1;
      bus_if.op_a  = 32'h0001_0000;
      bus_if.op_b  = 32'h0001_0000;
      @(negedge clk);
      bus_if.start = 1'b0;
      chk("b2b.rerun_busy", {62'd0, bus_if.busy, bus_if.done}, 64'd2);
      wait_done(bn, seen);
      chk("b2b.second_done", 64'(seen), 64'd1);
      chk("b2b.second_busy_cycles", 64'(bn), 64'd32);
      chk("b2b.second_product", {bus_if.result_hi, bus_if.result_lo}, 64'h0000_0001_0000_0000);
      @(negedge clk);

      // Asynchronous reset in the middle of a run.
      launch(32'h0000_ABCD, 32'h0000_1234);
      repeat (5) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("areset.busy_done", {62'd0, bus_if.busy, bus_if.done}, 64'd0);
      chk("areset.result", {bus_if.result_hi, bus_if.result_lo}, 64'd0);
      chk("areset.zero", 64'(bus_if.result_zero), 64'd0);
      #2 rst_n = 1'b1;
      extra = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (bus_if.done || bus_if.busy) extra++;
      end
      chk("areset.no_done", 64'(extra), 64'd0);
      model = 64'(32'h0000_ABCD) * 64'(32'h0000_1234);
      run_check("areset.recover", 32'h0000_ABCD, 32'h0000_1234, model, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
